// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm arming/delay controller: state codes,
// counter geometry and default delay preloads.
package alarm_pkg;

    localparam int STATE_W = 3;
    localparam int CNT_W   = 3;

    typedef enum logic [STATE_W-1:0] {
        S_DISARMED    = 3'd0,
        S_EXIT_DELAY  = 3'd1,
        S_ARMED       = 3'd2,
        S_ENTRY_DELAY = 3'd3,
        S_ALARM       = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_TERM       = 3'd7;
    localparam logic [CNT_W-1:0] EXIT_LOAD_DEF  = 3'd0;
    localparam logic [CNT_W-1:0] ENTRY_LOAD_DEF = 3'd2;

    function automatic logic is_delay(input state_t s);
        return (s == S_EXIT_DELAY) || (s == S_ENTRY_DELAY);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks;
// clr restarts the period so each state sees a full first tick interval.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clock50,
    input  logic Mr_n,
    input  logic clr,
    output logic tick
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (clr || (cnt_q == LAST)) cnt_d = '0;
    end

    always_ff @(posedge clock50 or negedge Mr_n) begin
        if (!Mr_n) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/alarm_delay_fsm.sv
// Arming/delay controller: sequences DISARMED -> EXIT -> ARMED -> ENTRY -> ALARM
// and drives the external 3-bit delay counter that times both delays.
module alarm_delay_fsm
    import alarm_pkg::*;
#(
    parameter int               TICK_DIV   = 50_000_000,
    parameter logic [CNT_W-1:0] EXIT_LOAD  = EXIT_LOAD_DEF,
    parameter logic [CNT_W-1:0] ENTRY_LOAD = ENTRY_LOAD_DEF
) (
    input  logic               clock50,
    input  logic               Mr_n,
    input  logic               arm,
    input  logic               disarm,
    input  logic               sensor,
    input  logic [CNT_W-1:0]   cnt_q,
    output logic               cnt_mr,
    output logic               cnt_en,
    output logic               cnt_load_en,
    output logic [CNT_W-1:0]   cnt_load_value,
    output logic [STATE_W-1:0] state,
    output logic               siren,
    output logic               armed_led,
    output logic               delay_active
);

    state_t state_q, state_d;
    logic   load_q, load_d;
    logic   tick;
    logic   expire;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clock50 (clock50),
        .Mr_n    (Mr_n),
        .clr     (state_d != state_q),
        .tick    (tick)
    );

    // Expiry is taken from Qout rather than the counter's Tc, which stays
    // asserted across a reload and would fire early on back-to-back delays.
    assign cnt_en = tick && is_delay(state_q);
    assign expire = cnt_en && (cnt_q == CNT_TERM);

    always_comb begin
        state_d = state_q;
        if (disarm) begin
            state_d = S_DISARMED;
        end else begin
            case (state_q)
                S_DISARMED:    if (arm)    state_d = S_EXIT_DELAY;
                S_EXIT_DELAY:  if (expire) state_d = S_ARMED;
                S_ARMED:       if (sensor) state_d = S_ENTRY_DELAY;
                S_ENTRY_DELAY: if (expire) state_d = S_ALARM;
                S_ALARM:       state_d = S_ALARM;
                default:       state_d = S_DISARMED;
            endcase
        end
        load_d = (state_d != state_q) && is_delay(state_d);
    end

    always_ff @(posedge clock50 or negedge Mr_n) begin
        if (!Mr_n) begin
            state_q <= S_DISARMED;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
        end
    end

    always_comb begin
        cnt_mr         = 1'b1;
        cnt_load_value = '0;
        siren          = 1'b0;
        armed_led      = 1'b0;
        delay_active   = 1'b0;
        case (state_q)
            S_EXIT_DELAY: begin
                cnt_mr         = 1'b0;
                cnt_load_value = EXIT_LOAD;
                delay_active   = 1'b1;
            end
            S_ARMED: armed_led = 1'b1;
            S_ENTRY_DELAY: begin
                cnt_mr         = 1'b0;
                cnt_load_value = ENTRY_LOAD;
                armed_led      = 1'b1;
                delay_active   = 1'b1;
            end
            S_ALARM: begin
                siren     = 1'b1;
                armed_led = 1'b1;
            end
            default: ;
        endcase
    end

    assign cnt_load_en = load_q;
    assign state       = state_q;

endmodule

// File: tb/tb_alarm_delay_fsm.sv
// Bench for alarm_delay_fsm with a behavioural 3-bit counter attached.
module tb_alarm_delay_fsm;

    localparam int         TD  = 4;
    localparam logic [2:0] EXL = 3'd0;
    localparam logic [2:0] ENL = 3'd2;

    logic       clock50 = 1'b0;
    logic       Mr_n    = 1'b0;
    logic       arm     = 1'b0;
    logic       disarm  = 1'b0;
    logic       sensor  = 1'b0;
    logic [2:0] cnt_q;
    logic       cnt_mr, cnt_en, cnt_load_en;
    logic [2:0] cnt_load_value, state;
    logic       siren, armed_led, delay_active;

    alarm_delay_fsm #(.TICK_DIV(TD), .EXIT_LOAD(EXL), .ENTRY_LOAD(ENL)) dut (
        .clock50        (clock50),
        .Mr_n           (Mr_n),
        .arm            (arm),
        .disarm         (disarm),
        .sensor         (sensor),
        .cnt_q          (cnt_q),
        .cnt_mr         (cnt_mr),
        .cnt_en         (cnt_en),
        .cnt_load_en    (cnt_load_en),
        .cnt_load_value (cnt_load_value),
        .state          (state),
        .siren          (siren),
        .armed_led      (armed_led),
        .delay_active   (delay_active)
    );

    always #5 clock50 = ~clock50;

    // The 3-bit delay counter sitting downstream of the controller.
    always_ff @(posedge clock50 or negedge Mr_n) begin
        if (!Mr_n)            cnt_q <= 3'd0;
        else if (cnt_mr)      cnt_q <= 3'd0;
        else if (cnt_load_en) cnt_q <= cnt_load_value;
        else if (cnt_en)      cnt_q <= cnt_q + 3'd1;
    end

    int checks   = 0;
    int failures = 0;

    // Reference: state plus cycles spent in it and cycles left in a delay.
    int m_state, m_age, m_rem;

    typedef struct {
        logic       a, d, s;
        logic [2:0] st;
        logic       le, mr;
    } vec_t;
    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_age = 0; m_rem = 0;
    endtask

    task automatic model_edge();
        int nxt;
        nxt = m_state;
        if (disarm) nxt = 0;
        else case (m_state)
            0: if (arm) nxt = 1;
            1: if (m_rem == 1) nxt = 2;
            2: if (sensor) nxt = 3;
            3: if (m_rem == 1) nxt = 4;
            default: nxt = m_state;
        endcase
        if (nxt != m_state) begin
            m_state = nxt;
            m_age   = 0;
            m_rem   = (nxt == 1) ? (8 - int'(EXL)) * TD :
                      (nxt == 3) ? (8 - int'(ENL)) * TD : 0;
        end else begin
            m_age++;
            if (m_rem > 0) m_rem--;
        end
    endtask

    task automatic check_model();
        logic dly;
        dly = (m_state == 1) || (m_state == 3);
        chk("state",        state,        m_state);
        chk("cnt_mr",       cnt_mr,       !dly);
        chk("cnt_en",       cnt_en,       dly && (m_age % TD == TD - 1));
        chk("cnt_load_en",  cnt_load_en,  dly && (m_age == 0));
        chk("cnt_load_val", cnt_load_value, (m_state == 1) ? EXL : (m_state == 3) ? ENL : 3'd0);
        chk("siren",        siren,        m_state == 4);
        chk("armed_led",    armed_led,    m_state >= 2);
        chk("delay_active", delay_active, dly);
    endtask

    task automatic cyc(input logic a, input logic d, input logic s);
        arm = a; disarm = d; sensor = s;
        @(posedge clock50);
        model_edge();
        @(negedge clock50);
        arm = 1'b0; disarm = 1'b0; sensor = 1'b0;
        check_model();
    endtask

    // Idle until state reaches target; n is the number of cycles it took.
    task automatic wait_state(input logic [2:0] target, output int n);
        n = 0;
        while (state != target && n < 100) begin
            cyc(1'b0, 1'b0, 1'b0);
            n++;
        end
    endtask

    initial begin
        int n;
        logic a, d, s;

        vt[0] = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1};
        vt[1] = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1};
        vt[2] = '{1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0};
        vt[3] = '{1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0};
        vt[4] = '{1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0};
        vt[5] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1};
        vt[6] = '{1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0};
        vt[7] = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1};

        // Reset held, then released; must stay quiet in DISARMED.
        model_reset();
        #12;
        chk("rst_state", state, 3'd0);
        chk("rst_mr", cnt_mr, 1'b1);
        chk("rst_siren", siren, 1'b0);
        chk("rst_en", cnt_en, 1'b0);
        chk("rst_load_en", cnt_load_en, 1'b0);
        @(negedge clock50);
        Mr_n = 1'b1;
        check_model();
        repeat (3) cyc(1'b0, 1'b0, 1'b0);

        // Directed table from DISARMED.
        for (int i = 0; i < 8; i++) begin
            cyc(vt[i].a, vt[i].d, vt[i].s);
            chk($sformatf("vec%0d_state", i), state, vt[i].st);
            chk($sformatf("vec%0d_load_en", i), cnt_load_en, vt[i].le);
            chk($sformatf("vec%0d_mr", i), cnt_mr, vt[i].mr);
        end

        // Exit delay, then sensor on the very first ARMED cycle.
        cyc(1'b1, 1'b0, 1'b0);
        chk("exit_load_en", cnt_load_en, 1'b1);
        wait_state(3'd2, n);
        chk("exit_len", n, 32);
        chk("armed_led", armed_led, 1'b1);
        chk("armed_delay_active", delay_active, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("b2b_entry", state, 3'd3);
        wait_state(3'd4, n);
        chk("b2b_entry_len", n, 24);
        chk("b2b_siren", siren, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        chk("alarm_hold", state, 3'd4);
        cyc(1'b0, 1'b1, 1'b0);
        chk("alarm_disarm", state, 3'd0);

        // Entry delay after lingering in ARMED.
        cyc(1'b1, 1'b0, 1'b0);
        wait_state(3'd2, n);
        repeat (5) cyc(1'b1, 1'b0, 1'b0);
        chk("armed_ignores_arm", state, 3'd2);
        cyc(1'b0, 1'b0, 1'b1);
        chk("entry_state", state, 3'd3);
        chk("entry_load_val", cnt_load_value, 3'd2);
        chk("entry_load_en", cnt_load_en, 1'b1);
        wait_state(3'd4, n);
        chk("entry_len", n, 24);
        chk("entry_siren", siren, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);

        // Disarm coincident with the expiry tick.
        cyc(1'b1, 1'b0, 1'b0);
        repeat (31) cyc(1'b0, 1'b0, 1'b0);
        chk("expiry_cnt_en", cnt_en, 1'b1);
        chk("expiry_cnt_q", cnt_q, 3'd7);
        cyc(1'b0, 1'b1, 1'b0);
        chk("disarm_wins", state, 3'd0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        chk("disarm_stays", state, 3'd0);

        // Asynchronous reset in the middle of ENTRY_DELAY.
        cyc(1'b1, 1'b0, 1'b0);
        wait_state(3'd2, n);
        cyc(1'b0, 1'b0, 1'b1);
        repeat (10) cyc(1'b0, 1'b0, 1'b0);
        #2 Mr_n = 1'b0;
        #1;
        chk("mid_rst_state", state, 3'd0);
        chk("mid_rst_en", cnt_en, 1'b0);
        chk("mid_rst_mr", cnt_mr, 1'b1);
        chk("mid_rst_led", armed_led, 1'b0);
        model_reset();
        @(posedge clock50);
        @(negedge clock50);
        Mr_n = 1'b1;
        check_model();
        cyc(1'b1, 1'b0, 1'b0);
        wait_state(3'd2, n);
        chk("rearm_exit_len", n, 32);
        cyc(1'b0, 1'b1, 1'b0);

        // Random traffic against the reference.
        for (int i = 0; i < 3000; i++) begin
            a = ($urandom_range(7) == 0);
            d = ($urandom_range(39) == 0);
            s = ($urandom_range(5) == 0);
            cyc(a, d, s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
